mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port memory arbiter, one outstanding access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: port 0 fixed priority).
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic        gnt0, gnt1;
  logic        tie_to1;
  logic        timeout;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer holds the port that wins the next tie, i.e. not the last granted.
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign tie_to1 = rr_q;
`else
  assign tie_to1 = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        m0_req && m1_req: begin
          gnt0 = !tie_to1;
          gnt1 = tie_to1;
        end
        m0_req && !m1_req: gnt0 = 1'b1;
        !m0_req && m1_req: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    // 256th wait cycle without ready; ready on that cycle still wins.
    timeout = !mem_ready && (cnt_q == 9'd255);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt0) begin
          state_d = SERVE0;
          addr_d  = m0_addr;
          wdata_d = m0_wdata;
          we_d    = m0_we;
        end else if (gnt1) begin
          state_d = SERVE1;
          addr_d  = m1_addr;
          wdata_d = m1_wdata;
          we_d    = m1_we;
        end
      end
      SERVE0, SERVE1: begin
        if (mem_ready || timeout) begin
          state_d = IDLE;
          ack0_d  = (state_q == SERVE0);
          ack1_d  = (state_q == SERVE1);
          err0_d  = timeout && (state_q == SERVE0);
          err1_d  = timeout && (state_q == SERVE1);
          if (mem_ready && !we_q) begin
            if (state_q == SERVE0) begin
              rd0_d = mem_rdata;
            end else begin
              rd1_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_err    = err0_q;
  assign m1_err    = err1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard for mem_arbiter.
// Define ARB_ROUND_ROBIN_EN to check the round-robin grant order.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        mem_en, mem_we, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int          ready_dly;
  logic [31:0] rdata_cfg;
  int          serve_cnt;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } vec_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          en;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd[2];
  int          checks;
  int          errors;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: ready on the (ready_dly+1)-th strobe cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) serve_cnt <= 0;
    else if (mem_en) serve_cnt <= serve_cnt + 1;
    else serve_cnt <= 0;
  end

  assign mem_ready = mem_en && (serve_cnt == ready_dly);
  assign mem_rdata = rdata_cfg;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input bit port, input bit we,
                                  input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  input logic [31:0] rdata,
                                  input int dly);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = (dly >= 256);
    e.en    = e.err ? 256 : dly + 1;
    if (!we && !e.err) last_rd[port] = rdata;
    e.rdata = last_rd[port];
    return e;
  endfunction

  task automatic monitor();
    int   en_run  = 0;
    int   bus_bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_run  = 0;
        bus_bad = 0;
      end else begin
        if (mem_en) begin
          en_run++;
          if (sb.size() > 0) begin
            if ({mem_we, mem_addr, mem_wdata} !==
                {sb[0].we, sb[0].addr, sb[0].wdata}) bus_bad++;
          end
        end
        if (m0_ack || m1_ack) begin
          check("ack_exclusive", 64'(m0_ack & m1_ack), 64'(0));
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got m0=%0b m1=%0b want none",
                     m0_ack, m1_ack);
          end else begin
            e = sb.pop_front();
            check("ack_port", 64'(m1_ack), 64'(e.port));
            check("err", 64'(e.port ? m1_err : m0_err), 64'(e.err));
            check("err_other", 64'(e.port ? m0_err : m1_err), 64'(0));
            check("rdata", 64'(e.port ? m1_rdata : m0_rdata),
                  64'(e.rdata));
            check("en_cycles", 64'(en_run), 64'(e.en));
            check("bus_stable", 64'(bus_bad), 64'(0));
          end
          en_run  = 0;
          bus_bad = 0;
        end else if (m0_err || m1_err) begin
          checks++;
          errors++;
          $display("FAIL err_without_ack: got m0=%0b m1=%0b want 0",
                   m0_err, m1_err);
        end
      end
    end
  endtask

  task automatic wait_ack(input bit port, input int exp_lat);
    int t   = 0;
    bit got = 1'b0;
    while (!got && t < 400) begin
      @(negedge clk);
      t++;
      got = port ? m1_ack : m0_ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: port %0d got no ack in %0d cycles, want ack",
               port, t);
    end else begin
      check("ack_latency", 64'(t - 1), 64'(exp_lat));
    end
    if (port) m1_req = 1'b0;
    else m0_req = 1'b0;
  endtask

  task automatic run_one(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    ready_dly = v.dly;
    rdata_cfg = v.rdata;
    e = mk_exp(v.port, v.we, v.addr, v.wdata, v.rdata, v.dly);
    sb.push_back(e);
    if (v.port) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    wait_ack(v.port, e.en + 1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   t;
    bit   gp;
    exp_t e;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0080, 32'h1111_2222, 32'h9999_9999, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0084, 32'h0, 32'h0BAD_F00D, 254};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0088, 32'h0, 32'h55AA_55AA, 255};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_008C, 32'h0, 32'hFFFF_FFFF, 1000};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0090, 32'h0, 32'h00C0_FFEE, 0};

    checks = 0;
    errors = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    ready_dly = 0;
    rdata_cfg = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({busy, mem_en, mem_we, m0_ack, m1_ack,
                           m0_err, m1_err}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_one(vecs[i]);

    // Reset on the 2nd SERVE1 cycle abandons the access silently.
    @(posedge clk);
    #1;
    ready_dly = 1000;
    rdata_cfg = 32'h7777_7777;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100; m1_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("busy_serve1", 64'({busy, mem_en}), 64'(2'b11));
    rst = 1'b1;
    #1;
    check("busy_in_rst", 64'(busy), 64'(0));
    check("mem_en_in_rst", 64'(mem_en), 64'(0));
    check("rdata_in_rst", {m0_rdata, m1_rdata}, 64'(0));
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(posedge clk);
    #1;
    ready_dly = 0;
    e = mk_exp(1'b1, 1'b0, 32'h100, 32'h0, 32'h7777_7777, 0);
    sb.push_back(e);
    rst = 1'b0;
    wait_ack(1'b1, 2);

    // Both ports requesting continuously for four accesses.
    apply_reset();
    ready_dly = 0;
    rdata_cfg = 32'h600D_0000;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      gp = (i % 2) == 1;
`else
      gp = 1'b0;
`endif
      e = mk_exp(gp, 1'b0, gp ? 32'h200 : 32'h100, 32'h0, rdata_cfg, 0);
      sb.push_back(e);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_wdata = '0;
    n = 0;
    t = 0;
    while (n < 4 && t < 100) begin
      @(negedge clk);
      t++;
      if (m0_ack || m1_ack) n++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("grant_count", 64'(n), 64'(4));

    repeat (4) @(posedge clk);
    #1;
    check("idle_at_end", 64'(busy), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
